// File: rtl/lsu_split.sv
// Load/store unit: sits between the executor and writeback. Drives a
// valid/ready memory bus with word-aligned beats. A misaligned access is
// split into two beats or trapped, depending on SPLIT_MISALIGNED. An
// optional per-beat timeout turns a stalled bus into a fault. Non-memory
// ops pass straight through to the output register one cycle later.
module lsu_split #(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int TIMEOUT          = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_rd_data,
    output logic              out_fault,
    output logic [1:0]        out_fault_code,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5,
                           OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;
    localparam logic [1:0] FC_MISALIGN = 2'd1, FC_TIMEOUT = 2'd2;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Faulting address is reported on the 32-bit result bus.
    function automatic logic [31:0] to32(input logic [ADDR_W-1:0] a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W && i < 32; i++) r[i] = a[i];
        return r;
    endfunction

    state_t state_q, state_d;

    // Access context held across the beats
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        m_hi_q, m_hi_d;
    logic [31:0]       wd_hi_q, wd_hi_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    // Bus request and result registers
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [31:0]       out_rd_data_q, out_rd_data_d;
    logic              out_fault_q, out_fault_d;
    logic [1:0]        out_fault_code_q, out_fault_code_d;

    logic        is_load, is_store, is_mem, misal, trap, accept;
    logic [3:0]  smask;
    logic [1:0]  off;
    logic [7:0]  m8;
    logic [63:0] d64;
    logic        held_store, last_beat, tmo_hit;
    logic [63:0] rd64;
    logic [31:0] sh32, load_val;

    assign in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode the incoming op into kind and size mask
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        smask    = 4'h0;
        case (in_op)
            OP_LB, OP_LBU: begin is_load  = 1'b1; smask = 4'h1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; smask = 4'h3; end
            OP_LW:         begin is_load  = 1'b1; smask = 4'hF; end
            OP_SB:         begin is_store = 1'b1; smask = 4'h1; end
            OP_SH:         begin is_store = 1'b1; smask = 4'h3; end
            OP_SW:         begin is_store = 1'b1; smask = 4'hF; end
            default: ;
        endcase
    end

    assign is_mem = is_load || is_store;
    assign off    = in_addr[1:0];
    assign m8     = {4'h0, smask} << off;
    assign d64    = {32'h0, in_wdata} << {off, 3'b000};
    assign misal  = ((smask == 4'h3) && off[0]) || ((smask == 4'hF) && (off != 2'd0));
    assign trap   = misal && !SPLIT_MISALIGNED;

    assign held_store = op_q[3];
    assign last_beat  = mem_ready && ((state_q == S_BEAT1) ||
                                      ((state_q == S_BEAT0) && (m_hi_q == 4'h0)));
    assign tmo_hit    = (TIMEOUT > 0) && (state_q != S_IDLE) && !mem_ready && (tmo_q == TMO_LAST);

    // Assemble the load result from one or two beats of read data
    always_comb begin
        rd64     = (state_q == S_BEAT1) ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
        sh32     = 32'(rd64 >> {off_q, 3'b000});
        load_val = sh32;
        case (op_q)
            OP_LB:   load_val = {{24{sh32[7]}}, sh32[7:0]};
            OP_LH:   load_val = {{16{sh32[15]}}, sh32[15:0]};
            OP_LBU:  load_val = {24'h0, sh32[7:0]};
            OP_LHU:  load_val = {16'h0, sh32[15:0]};
            default: load_val = sh32;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mem && !trap) state_d = S_BEAT0;
            S_BEAT0: if (mem_ready)    state_d = (m_hi_q != 4'h0) ? S_BEAT1 : S_IDLE;
                     else if (tmo_hit) state_d = S_IDLE;
            S_BEAT1: if (mem_ready || tmo_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request, beat context and result next-state
    always_comb begin
        op_d             = op_q;
        off_d            = off_q;
        rd_d             = rd_q;
        addr_d           = addr_q;
        m_hi_d           = m_hi_q;
        wd_hi_d          = wd_hi_q;
        rdata0_d         = rdata0_q;
        tmo_d            = tmo_q;
        mem_valid_d      = mem_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wstrb_d      = mem_wstrb_q;
        mem_wdata_d      = mem_wdata_q;
        out_valid_d      = out_valid_q && !out_ready;
        out_rd_d         = out_rd_q;
        out_rd_data_d    = out_rd_data_q;
        out_fault_d      = out_fault_q;
        out_fault_code_d = out_fault_code_q;

        if (accept && !is_mem) begin
            out_valid_d      = 1'b1;
            out_rd_d         = in_rd;
            out_rd_data_d    = in_rd_data;
            out_fault_d      = 1'b0;
            out_fault_code_d = 2'd0;
        end else if (accept && trap) begin
            out_valid_d      = 1'b1;
            out_rd_d         = 5'd0;
            out_rd_data_d    = to32(in_addr);
            out_fault_d      = 1'b1;
            out_fault_code_d = FC_MISALIGN;
        end else if (accept) begin
            op_d        = in_op;
            off_d       = off;
            rd_d        = in_rd;
            addr_d      = in_addr;
            m_hi_d      = m8[7:4];
            wd_hi_d     = d64[63:32];
            tmo_d       = '0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_d = is_store ? m8[3:0] : 4'h0;
            mem_wdata_d = d64[31:0];
        end else if (last_beat) begin
            mem_valid_d      = 1'b0;
            out_valid_d      = 1'b1;
            out_rd_d         = held_store ? 5'd0 : rd_q;
            out_rd_data_d    = held_store ? 32'h0 : load_val;
            out_fault_d      = 1'b0;
            out_fault_code_d = 2'd0;
        end else if ((state_q == S_BEAT0) && mem_ready) begin
            rdata0_d    = mem_rdata;
            tmo_d       = '0;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wstrb_d = held_store ? m_hi_q : 4'h0;
            mem_wdata_d = wd_hi_q;
        end else if (tmo_hit) begin
            mem_valid_d      = 1'b0;
            out_valid_d      = 1'b1;
            out_rd_d         = 5'd0;
            out_rd_data_d    = to32(addr_q);
            out_fault_d      = 1'b1;
            out_fault_code_d = FC_TIMEOUT;
        end else if ((TIMEOUT > 0) && (state_q != S_IDLE)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q             <= '0;
            off_q            <= '0;
            rd_q             <= '0;
            addr_q           <= '0;
            m_hi_q           <= '0;
            wd_hi_q          <= '0;
            rdata0_q         <= '0;
            tmo_q            <= '0;
            mem_valid_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_wstrb_q      <= '0;
            mem_wdata_q      <= '0;
            out_valid_q      <= 1'b0;
            out_rd_q         <= '0;
            out_rd_data_q    <= '0;
            out_fault_q      <= 1'b0;
            out_fault_code_q <= '0;
        end else begin
            op_q             <= op_d;
            off_q            <= off_d;
            rd_q             <= rd_d;
            addr_q           <= addr_d;
            m_hi_q           <= m_hi_d;
            wd_hi_q          <= wd_hi_d;
            rdata0_q         <= rdata0_d;
            tmo_q            <= tmo_d;
            mem_valid_q      <= mem_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wstrb_q      <= mem_wstrb_d;
            mem_wdata_q      <= mem_wdata_d;
            out_valid_q      <= out_valid_d;
            out_rd_q         <= out_rd_d;
            out_rd_data_q    <= out_rd_data_d;
            out_fault_q      <= out_fault_d;
            out_fault_code_q <= out_fault_code_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign mem_wdata      = mem_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_rd         = out_rd_q;
    assign out_rd_data    = out_rd_data_q;
    assign out_fault      = out_fault_q;
    assign out_fault_code = out_fault_code_q;

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split. Two instances share one stimulus stream:
// u_split splits misaligned accesses with no timeout, u_trap traps them and
// has a 4-cycle bus timeout. Inputs change on the falling edge, outputs are
// sampled on the falling edge before the inputs move.
module tb_lsu_split;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, mem_ready = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_addr = '0, in_wdata = '0, in_rd_data = '0, mem_rdata = '0;
    logic [4:0]  in_rd = '0;

    logic        s_in_ready, s_out_valid, s_out_fault, s_mem_valid;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_out_fault_code;
    logic [31:0] s_out_rd_data, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;

    logic        t_in_ready, t_out_valid, t_out_fault, t_mem_valid;
    logic [4:0]  t_out_rd;
    logic [1:0]  t_out_fault_code;
    logic [31:0] t_out_rd_data, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_wstrb;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lsu_split #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1), .TIMEOUT(0)) u_split (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_rd_data(in_rd_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_rd(s_out_rd),
        .out_rd_data(s_out_rd_data), .out_fault(s_out_fault), .out_fault_code(s_out_fault_code),
        .mem_valid(s_mem_valid), .mem_ready(mem_ready), .mem_addr(s_mem_addr),
        .mem_wstrb(s_mem_wstrb), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_split #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0), .TIMEOUT(4)) u_trap (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_rd_data(in_rd_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_rd(t_out_rd),
        .out_rd_data(t_out_rd_data), .out_fault(t_out_fault), .out_fault_code(t_out_fault_code),
        .mem_valid(t_mem_valid), .mem_ready(mem_ready), .mem_addr(t_mem_addr),
        .mem_wstrb(t_mem_wstrb), .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present one op for a single accept edge, return on the following falling edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdd, input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd; in_rd_data = rdd; in_rd = rd;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) cyc();
        chk("rst_in_ready",  {31'b0, s_in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, s_out_valid}, 32'd0);
        chk("rst_fault",     {30'b0, s_out_fault, t_out_fault}, 32'd0);
        chk("rst_code",      {30'b0, s_out_fault_code}, 32'd0);
        chk("rst_out_rd",    {27'b0, s_out_rd}, 32'd0);
        chk("rst_rd_data",   s_out_rd_data, 32'd0);
        chk("rst_mem_valid", {30'b0, s_mem_valid, t_mem_valid}, 32'd0);
        chk("rst_mem_addr",  s_mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'b0, s_mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", s_mem_wdata, 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_in_ready", {31'b0, s_in_ready}, 32'd1);

        // pass-through, then an undefined op back to back
        issue(4'd0, 32'h0, 32'h0, 32'hCAFEF00D, 5'd3);
        chk("none_valid", {31'b0, s_out_valid}, 32'd1);
        chk("none_rd",    {27'b0, s_out_rd}, 32'd3);
        chk("none_data",  s_out_rd_data, 32'hCAFEF00D);
        chk("none_nobus", {31'b0, s_mem_valid}, 32'd0);
        issue(4'd6, 32'h0, 32'h0, 32'h0BADC0DE, 5'd4);
        chk("op6_valid", {31'b0, t_out_valid}, 32'd1);
        chk("op6_data",  t_out_rd_data, 32'h0BADC0DE);
        cyc();
        chk("none_drain", {31'b0, s_out_valid}, 32'd0);

        // LW aligned, ready at first sight: result at T+2
        issue(4'd3, 32'h100, 32'h0, 32'h0, 5'd5);
        chk("lw_mem_valid", {31'b0, s_mem_valid}, 32'd1);
        chk("lw_mem_addr",  s_mem_addr, 32'h100);
        chk("lw_wstrb",     {28'b0, s_mem_wstrb}, 32'd0);
        chk("lw_not_yet",   {31'b0, s_out_valid}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        chk("lw_valid",     {31'b0, s_out_valid}, 32'd1);
        chk("lw_rd",        {27'b0, s_out_rd}, 32'd5);
        chk("lw_data",      s_out_rd_data, 32'hDEADBEEF);
        chk("lw_bus_idle",  {31'b0, s_mem_valid}, 32'd0);
        chk("lw_trap_data", t_out_rd_data, 32'hDEADBEEF);
        mem_ready = 1'b0;

        // LB / LBU at byte 3
        issue(4'd1, 32'h103, 32'h0, 32'h0, 5'd6);
        chk("lb_mem_addr", s_mem_addr, 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'h80FF0000;
        cyc();
        chk("lb_data", s_out_rd_data, 32'hFFFFFF80);
        mem_ready = 1'b0;
        issue(4'd4, 32'h103, 32'h0, 32'h0, 5'd6);
        mem_ready = 1'b1;
        cyc();
        chk("lbu_data", t_out_rd_data, 32'h00000080);
        mem_ready = 1'b0;
        cyc();

        // aligned SH to upper half: single beat
        issue(4'd9, 32'h102, 32'hAAAA5555, 32'h0, 5'd8);
        chk("sh_wstrb", {28'b0, s_mem_wstrb}, 32'hC);
        chk("sh_wdata", t_mem_wdata, 32'h55550000);
        mem_ready = 1'b1;
        cyc();
        chk("sh_valid", {31'b0, s_out_valid}, 32'd1);
        chk("sh_rd",    {27'b0, s_out_rd}, 32'd0);
        mem_ready = 1'b0;
        cyc();

        // misaligned SW: split on u_split, trap on u_trap
        issue(4'd10, 32'h102, 32'h11223344, 32'h0, 5'd7);
        chk("sw_b0_addr",   s_mem_addr, 32'h100);
        chk("sw_b0_wstrb",  {28'b0, s_mem_wstrb}, 32'hC);
        chk("sw_b0_wdata",  s_mem_wdata, 32'h33440000);
        chk("sw_trap_flt",  {29'b0, t_out_valid, t_out_fault_code}, 32'b101);
        chk("sw_trap_addr", t_out_rd_data, 32'h102);
        chk("sw_trap_bus",  {31'b0, t_mem_valid}, 32'd0);
        cyc();
        chk("sw_b0_hold",   s_mem_addr, 32'h100);
        chk("sw_b0_hold_v", {31'b0, s_mem_valid}, 32'd1);
        mem_ready = 1'b1;
        cyc();
        chk("sw_b1_addr",   s_mem_addr, 32'h104);
        chk("sw_b1_wstrb",  {28'b0, s_mem_wstrb}, 32'h3);
        chk("sw_b1_wdata",  s_mem_wdata, 32'h00001122);
        chk("sw_b1_valid",  {31'b0, s_mem_valid}, 32'd1);
        cyc();
        chk("sw_done",      {31'b0, s_out_valid}, 32'd1);
        chk("sw_rd",        {27'b0, s_out_rd}, 32'd0);
        chk("sw_bus_idle",  {31'b0, s_mem_valid}, 32'd0);
        mem_ready = 1'b0;
        cyc();

        // LH across the word boundary: result at T+3
        issue(4'd2, 32'h1FF, 32'h0, 32'h0, 5'd9);
        chk("lh_b0_addr",  s_mem_addr, 32'h1FC);
        chk("lh_trap_flt", {29'b0, t_out_valid, t_out_fault_code}, 32'b101);
        chk("lh_trap_adr", t_out_rd_data, 32'h1FF);
        mem_ready = 1'b1; mem_rdata = 32'hAB000000;
        cyc();
        chk("lh_b1_addr",  s_mem_addr, 32'h200);
        chk("lh_b1_wstrb", {28'b0, s_mem_wstrb}, 32'h0);
        chk("lh_not_yet",  {31'b0, s_out_valid}, 32'd0);
        mem_rdata = 32'h000000CD;
        cyc();
        chk("lh_valid",    {31'b0, s_out_valid}, 32'd1);
        chk("lh_data",     s_out_rd_data, 32'hFFFFCDAB);
        mem_ready = 1'b0;
        cyc();

        // LW at 0x101: trap (no bus) vs. two-beat load
        issue(4'd3, 32'h101, 32'h0, 32'h0, 5'd10);
        chk("lw101_trap",   {29'b0, t_out_fault, t_out_fault_code}, 32'b101);
        chk("lw101_tadr",   t_out_rd_data, 32'h101);
        chk("lw101_trd",    {27'b0, t_out_rd}, 32'd0);
        chk("lw101_tbus",   {31'b0, t_mem_valid}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h44332211;
        cyc();
        mem_rdata = 32'h88776655;
        cyc();
        chk("lw101_split",  s_out_rd_data, 32'h55443322);
        mem_ready = 1'b0;
        cyc();

        // timeout on u_trap with the output stalled; u_split stays in its beat
        out_ready = 1'b0;
        issue(4'd3, 32'h200, 32'h0, 32'h0, 5'd2);
        chk("tmo_start", {31'b0, t_mem_valid}, 32'd1);
        repeat (3) cyc();
        chk("tmo_stall4", {31'b0, t_mem_valid}, 32'd1);
        cyc();
        chk("tmo_drop",   {31'b0, t_mem_valid}, 32'd0);
        chk("tmo_fault",  {29'b0, t_out_valid, t_out_fault_code}, 32'b110);
        chk("tmo_addr",   t_out_rd_data, 32'h200);
        chk("tmo_rd",     {27'b0, t_out_rd}, 32'd0);
        chk("tmo_in_rdy", {31'b0, t_in_ready}, 32'd0);
        in_valid = 1'b1; in_op = 4'd0; in_rd = 5'd9; in_rd_data = 32'h12345678;
        cyc();
        chk("hold_valid", {30'b0, t_out_valid, t_in_ready}, 32'b10);
        chk("hold_code",  {30'b0, t_out_fault_code}, 32'd2);
        cyc();
        chk("hold_addr",  t_out_rd_data, 32'h200);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("next_valid", {31'b0, t_out_valid}, 32'd1);
        chk("next_rd",    {27'b0, t_out_rd}, 32'd9);
        chk("next_data",  t_out_rd_data, 32'h12345678);
        chk("next_fault", {31'b0, t_out_fault}, 32'd0);
        cyc();
        chk("next_drain", {31'b0, t_out_valid}, 32'd0);

        // reset while u_split still holds its request
        chk("mid_beat_v", {31'b0, s_mem_valid}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst_mid_v",  {31'b0, s_mem_valid}, 32'd0);
        chk("rst_mid_rdy", {31'b0, s_in_ready}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("post_rst_rdy", {31'b0, s_in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Parametrised load/store unit between the executor and the writeback stage; next generation of the single-beat memory accessor.
- Adds a full valid/ready memory bus, configurable address width, and misaligned-access handling (split into two aligned beats, or trap).
- Adds an optional bus timeout fault and a skid-free output register with proper backpressure.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
ADDR_W, 32, byte-address width of in_addr/mem_addr
SPLIT_MISALIGNED, 1, 1 = misaligned access split into two aligned beats; 0 = misaligned access faults with no bus traffic
TIMEOUT, 0, max cycles to wait per beat for mem_ready; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  executor result valid
in_ready  out  1  unit accepts input this cycle
in_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; others treated as none
in_addr  in  ADDR_W  effective byte address
in_wdata  in  32  store data
in_rd  in  5  destination register
in_rd_data  in  32  pass-through result for op none
out_valid  out  1  result valid
out_ready  in  1  writeback accepts
out_rd  out  5  destination; 0 for stores and faults
out_rd_data  out  32  load/pass-through result; faulting address (zero-extended/truncated to 32) on fault
out_fault  out  1  access faulted
out_fault_code  out  2  1 misaligned trap, 2 timeout
mem_valid  out  1  bus request
mem_ready  in  1  bus completes beat this cycle
mem_addr  out  ADDR_W  word-aligned beat address (low 2 bits always 0)
mem_wstrb  out  4  byte strobes; 0000 = read
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_valid && mem_ready

Behaviour:
- Reset: state IDLE, in_ready 0 during reset, out_valid 0, out_fault 0, out_fault_code 0, out_rd 0, out_rd_data 0, mem_valid 0, mem_addr 0, mem_wstrb 0, mem_wdata 0, timeout counter 0.
- Input handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). Transfer on in_valid && in_ready.
- Output: out_* held stable while out_valid && !out_ready; out_valid clears on the out_ready cycle unless a new result loads that same cycle.
- States: IDLE, BEAT0, BEAT1.
- Transfer of op none → out_valid next cycle, out_rd/out_rd_data from input; state stays IDLE.
- Memory op, offset o = in_addr[1:0], size s = 1/2/4 bytes. Byte mask m8 = ((1<<s)-1) << o (8 bits). Shifted data d64 = {32'b0, in_wdata} << 8*o.
- Misaligned iff o is not a multiple of s.
- Misaligned && !SPLIT_MISALIGNED → fault 1 next cycle, no bus request.
- IDLE→BEAT0: mem_valid=1, mem_addr = in_addr with low 2 bits cleared, mem_wstrb = store ? m8[3:0] : 0, mem_wdata = d64[31:0].
- Requests: mem_valid, mem_addr, mem_wstrb, mem_wdata are held stable until mem_ready.
- BEAT0 on mem_ready: capture rdata0.
  - If m8[7:4] != 0: go to BEAT1, mem_addr += 4 (wraps modulo 2^ADDR_W), mem_wstrb = store ? m8[7:4] : 0, mem_wdata = d64[63:32], mem_valid stays high.
  - Otherwise: mem_valid=0, IDLE, result registered.
- BEAT1 on mem_ready: mem_valid=0, IDLE, result registered.
- Load result: v = ({rdata1, rdata0} >> 8*o)[s*8-1:0], sign-extended for LB/LH, zero-extended for LBU/LHU/LW.
- Latency from accept cycle T with mem_ready=1 at first sight: aligned out_valid at T+2; split out_valid at T+3.
- Timeout (TIMEOUT>0): counter clears at each beat start and counts cycles with mem_valid && !mem_ready. On reaching TIMEOUT: mem_valid drops, fault 2 output, IDLE. A split store's first beat may already be committed.
- Stores: out_valid pulses with out_rd=0 so writeback retires in order.
- Reset mid-beat: mem_valid low the following cycle; the bus must tolerate an abandoned request.

Test Plan:
- LW addr 0x100, mem_ready same cycle, rdata 0xDEADBEEF → out_rd_data 0xDEADBEEF at T+2, one beat, wstrb 0000.
- LB addr 0x103, rdata 0x80FF0000 → out_rd_data 0xFFFFFF80; LBU same → 0x00000080.
- SPLIT=1, SW addr 0x102, wdata 0x11223344 → beat 0x100 wstrb 1100 wdata 0x33440000; beat 0x104 wstrb 0011 wdata 0x00001122; out_rd=0.
- SPLIT=1, LH addr 0x1FF, rdata0 0xAB000000, rdata1 0x000000CD → out_rd_data 0xFFFFCDAB at T+3.
- SPLIT=0, LW addr 0x101 → no mem_valid, out_fault=1, code 1, out_rd_data 0x101 at T+1.
- TIMEOUT=4, mem_ready held 0 → mem_valid drops after 4 stall cycles, fault code 2. Also hold out_ready=0 across two results: output holds, in_ready stays 0.
